// File: rtl/binary2gray_density.sv
// Sliding-window white-pixel density: rebuilds a 12-bit gray stream from a
// binarized (0/4095) pixel stream using the last WIN valid pixels of the line.
module binary2gray_density #(
  parameter int unsigned WIN      = 8,
  parameter int unsigned LOG2_WIN = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic [11:0] iDATA,
  input  logic        iSOL,
  output logic        oDVAL,
  output logic [11:0] oDATA,
  output logic        oWIN_FULL
);

  localparam int unsigned CW    = LOG2_WIN + 1;
  localparam int unsigned SHIFT = 12 - LOG2_WIN;
  localparam int unsigned SW    = 13;

  logic [WIN-1:0] win;
  logic [CW-1:0]  count;
  logic [CW-1:0]  fill;

  logic           white;
  logic [WIN-1:0] win_next;
  logic [CW-1:0]  count_next;
  logic [CW-1:0]  fill_next;
  logic [SW-1:0]  scaled;
  logic [11:0]    gray_next;

  // Threshold compare over the full word; equivalent to testing bit 11.
  assign white = (iDATA >= 12'd2048);

  // Next window state for an accepted pixel.
  always_comb begin
    win_next   = win;
    count_next = count;
    fill_next  = fill;
    if (iSOL) begin
      win_next   = WIN'(white);
      count_next = CW'(white);
      fill_next  = CW'(1);
    end else begin
      win_next   = {win[WIN-2:0], white};
      count_next = count + CW'(white) - CW'(win[WIN-1]);
      fill_next  = (fill == CW'(WIN)) ? fill : fill + CW'(1);
    end
  end

  // A full window scales to exactly 4096, which clamps to full white.
  always_comb begin
    scaled    = SW'(count_next) << SHIFT;
    gray_next = scaled[SW-1] ? 12'hFFF : scaled[11:0];
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      win       <= '0;
      count     <= '0;
      fill      <= '0;
      oDVAL     <= 1'b0;
      oDATA     <= 12'd0;
      oWIN_FULL <= 1'b0;
    end else begin
      oDVAL <= iDVAL;
      if (iDVAL) begin
        win       <= win_next;
        count     <= count_next;
        fill      <= fill_next;
        oDATA     <= gray_next;
        oWIN_FULL <= (fill_next == CW'(WIN));
      end
    end
  end

endmodule

// File: tb/tb_binary2gray_density.sv
// Bench for binary2gray_density: directed vector table, hand sequences and a
// randomized run against a queue-based window model.
module tb_binary2gray_density;

  localparam int unsigned WIN      = 8;
  localparam int unsigned LOG2_WIN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dval = 1'b0;
  logic        sol = 1'b0;
  logic [11:0] data = 12'd0;
  logic        out_dval;
  logic [11:0] out_data;
  logic        out_full;

  int checks = 0;
  int errors = 0;

  binary2gray_density #(.WIN(WIN), .LOG2_WIN(LOG2_WIN)) dut (
    .iCLK     (clk),
    .iRST     (rst),
    .iDVAL    (dval),
    .iDATA    (data),
    .iSOL     (sol),
    .oDVAL    (out_dval),
    .oDATA    (out_data),
    .oWIN_FULL(out_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        dval;
    logic        sol;
    logic [11:0] data;
    logic        exp_dval;
    logic [11:0] exp_data;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic s, input int d,
                     input logic ev, input int ed, input logic ef);
    vec_t t;
    t.rst = r; t.dval = v; t.sol = s; t.data = 12'(d);
    t.exp_dval = ev; t.exp_data = 12'(ed); t.exp_full = ef;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs just after the edge.
  task automatic step(input logic r, input logic v, input logic s, input int d);
    rst = r; dval = v; sol = s; data = 12'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic ev, input int ed, input logic ef);
    check({name, ".dval"}, 32'(out_dval), 32'(ev));
    check({name, ".data"}, 32'(out_data), 32'(ed));
    check({name, ".full"}, 32'(out_full), 32'(ef));
  endtask

  // Reference model: bits of the current line, oldest first, at most WIN long.
  int unsigned line_q[$];
  logic        m_dval;
  int unsigned m_data;
  logic        m_full;

  task automatic model_step(input logic r, input logic v, input logic s, input int d);
    int unsigned sum;
    if (!r) begin
      line_q.delete();
      m_dval = 1'b0; m_data = 0; m_full = 1'b0;
      return;
    end
    m_dval = v;
    if (v) begin
      if (s) line_q.delete();
      line_q.push_back((d >= 2048) ? 1 : 0);
      if (line_q.size() > WIN) void'(line_q.pop_front());
      sum = 0;
      foreach (line_q[i]) sum += line_q[i];
      m_data = (sum * 4096) / WIN;
      if (m_data > 4095) m_data = 4095;
      m_full = (line_q.size() == WIN);
    end
  endtask

  initial begin
    // Reset held with active input
    for (int i = 0; i < 3; i++) add(0, 1, 0, 4095, 0, 0, 0);
    // Ramp up: 8 white, first flagged as start of line
    for (int i = 1; i <= 8; i++)
      add(1, 1, (i == 1), 4095, 1, (i == 8) ? 4095 : i * 512, (i == 8));
    // Ramp down: 8 black
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 0, 1, (8 - i) * 512, 1);
    // Stalls and threshold edge
    add(1, 0, 0, 4095, 0, 0, 1);
    add(1, 0, 0, 4095, 0, 0, 1);
    add(1, 1, 0, 2048, 1, 512, 1);
    add(1, 0, 0, 0, 0, 512, 1);
    add(1, 1, 0, 2047, 1, 512, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 1, 4095, 0, 512, 1);
    add(1, 1, 0, 2048, 1, 1024, 1);
    add(1, 1, 0, 4095, 1, 1536, 1);
    // Refill to all white
    add(1, 1, 0, 4095, 1, 2048, 1);
    add(1, 1, 0, 4095, 1, 2560, 1);
    add(1, 1, 0, 4095, 1, 3072, 1);
    add(1, 1, 0, 4095, 1, 3584, 1);
    add(1, 1, 0, 4095, 1, 3584, 1);
    add(1, 1, 0, 4095, 1, 4095, 1);
    add(1, 1, 0, 4095, 1, 4095, 1);
    add(1, 1, 0, 4095, 1, 4095, 1);
    // Line restart on a white pixel
    add(1, 1, 1, 4095, 1, 512, 0);
    add(1, 1, 0, 4095, 1, 1024, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].dval, vecs[i].sol, int'(vecs[i].data));
      check_out($sformatf("vec%0d", i), vecs[i].exp_dval, int'(vecs[i].exp_data),
                vecs[i].exp_full);
    end

    // iSOL without iDVAL must not restart the line
    step(1, 0, 1, 4095);
    check_out("sol_nodval_gap", 0, 1024, 0);
    step(1, 1, 0, 4095);
    check_out("sol_nodval_next", 1, 1536, 0);

    // Reset mid-line discards history even without iSOL afterwards
    step(1, 1, 1, 4095);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4095);
    check_out("midline_pre", 1, 2560, 0);
    step(0, 0, 0, 0);
    check_out("midline_rst", 0, 0, 0);
    step(1, 1, 0, 4095);
    check_out("midline_after", 1, 512, 0);

    // Randomized run against the model
    step(0, 0, 0, 0);
    model_step(0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, v, s;
      int d;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: d = 0;
        1: d = 4095;
        2: d = 2047 + int'($urandom_range(0, 1));
        default: d = int'($urandom_range(0, 4095));
      endcase
      step(r, v, s, d);
      model_step(r, v, s, d);
      check_out($sformatf("rnd%0d", n), m_dval, int'(m_data), m_full);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
